// File: rtl/mem_lsu_ctrl.sv
// Load/store sequencer between execute and the dual-port data memory: one request in, one memory access, one response out.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses without touching memory.
module mem_lsu_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pLsu_iValid,
    output logic                  pLsu_oReady,
    input  logic                  pLsu_iWrEn,
    input  logic [2:0]            pLsu_iFunc,
    input  logic [ADDR_WIDTH-1:0] pLsu_iAddr,
    input  logic [DATA_WIDTH-1:0] pLsu_iWrData,
    output logic                  pLsu_oValid,
    input  logic                  pLsu_iReady,
    output logic [DATA_WIDTH-1:0] pLsu_oRdData,
    output logic                  pLsu_oErr,
    output logic                  pMem_bRdEn,
    output logic [ADDR_WIDTH-1:0] pMem_bRdAddrB,
    input  logic [DATA_WIDTH-1:0] pMem_bRdDataB,
    output logic                  pMem_bWrEn,
    output logic [ADDR_WIDTH-1:0] pMem_bWrAddr,
    output logic [DATA_WIDTH-1:0] pMem_bWrData,
    output logic [3:0]            pMem_bWrMask
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_wr;
    logic [2:0]            r_func;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [3:0]            r_wr_mask;

    logic                  w_illegal;
    logic                  w_misalign;
    logic                  w_err;
    logic [3:0]            w_wr_mask;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_ext_data;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    // Legal loads: B, H, W, BU, HU. Legal stores: B, H, W.
    assign w_illegal = pLsu_iWrEn ? (pLsu_iFunc >= 3'b011)
                                  : ((pLsu_iFunc == 3'b011) || (pLsu_iFunc[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((pLsu_iFunc[1:0] == 2'b01) && pLsu_iAddr[0])
                     || ((pLsu_iFunc[1:0] == 2'b10) && (pLsu_iAddr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_illegal || w_misalign;

    // Store lane mask and right-justified data with unused bytes cleared.
    always_comb begin
        w_wr_mask = 4'b1111;
        w_wr_data = pLsu_iWrData;
        case (pLsu_iFunc[1:0])
            2'b00: begin
                w_wr_mask = 4'b0001;
                w_wr_data = DATA_WIDTH'(pLsu_iWrData[7:0]);
            end
            2'b01: begin
                w_wr_mask = 4'b0011;
                w_wr_data = DATA_WIDTH'(pLsu_iWrData[15:0]);
            end
            default: begin
                w_wr_mask = 4'b1111;
                w_wr_data = pLsu_iWrData;
            end
        endcase
    end

    // Load extension of the memory word according to the latched func.
    always_comb begin
        w_ext_data = pMem_bRdDataB;
        case (r_func)
            3'b000:  w_ext_data = {{(DATA_WIDTH-8){pMem_bRdDataB[7]}}, pMem_bRdDataB[7:0]};
            3'b100:  w_ext_data = DATA_WIDTH'(pMem_bRdDataB[7:0]);
            3'b001:  w_ext_data = {{(DATA_WIDTH-16){pMem_bRdDataB[15]}}, pMem_bRdDataB[15:0]};
            3'b101:  w_ext_data = DATA_WIDTH'(pMem_bRdDataB[15:0]);
            default: w_ext_data = pMem_bRdDataB;
        endcase
    end

    assign w_rsp_data = r_wr ? '0 : w_ext_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            r_wr      <= 1'b0;
            r_func    <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_mask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pLsu_iValid && r_ready) begin
                        r_ready <= 1'b0;
                        r_wr    <= pLsu_iWrEn;
                        r_func  <= pLsu_iFunc;
                        if (w_err) begin
                            // Error responses skip the memory entirely.
                            r_state   <= ST_RESP;
                            r_valid   <= 1'b1;
                            r_err     <= 1'b1;
                            r_rd_data <= '0;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_err   <= 1'b0;
                            if (pLsu_iWrEn) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= pLsu_iAddr;
                                r_wr_data <= w_wr_data;
                                r_wr_mask <= w_wr_mask;
                            end else begin
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= pLsu_iAddr;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    r_wr_en <= 1'b0;
                    if (MEM_LATENCY == 1) begin
                        r_rd_en   <= 1'b0;
                        r_rd_data <= w_rsp_data;
                        r_valid   <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt   <= CNT_W'(MEM_LATENCY - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_rd_en   <= 1'b0;
                        r_rd_data <= w_rsp_data;
                        r_valid   <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (pLsu_iReady) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pLsu_oReady   = r_ready;
    assign pLsu_oValid   = r_valid;
    assign pLsu_oRdData  = r_rd_data;
    assign pLsu_oErr     = r_err;
    assign pMem_bRdEn    = r_rd_en;
    assign pMem_bRdAddrB = r_rd_addr;
    assign pMem_bWrEn    = r_wr_en;
    assign pMem_bWrAddr  = r_wr_addr;
    assign pMem_bWrData  = r_wr_data;
    assign pMem_bWrMask  = r_wr_mask;

endmodule
